weight_update_nn: RTL and testbench
===================================

# weight_update_nn

Sequential weight-update stage for the 2-3-2 backprop network. It sits directly downstream of the delta calculation stage and consumes its per-layer deltas, together with the forward-pass activations and network input. It applies one gradient-descent step to every hidden and output weight and bias, using a single time-multiplexed multiplier path. It holds the network's weight registers and drives them back to the forward and delta stages.

## Interface
- N_IN, 2, network inputs
- N_HL_P, 3, hidden perceptrons
- N_OUT, 2, output perceptrons
- WIDTH, 32, signed fixed-point word width
- FRAC, 24, fractional bits
- LR, 32'h0080_0000, learning rate in the same Q format (0.5)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  deltas/activations valid; accepted only in IDLE
- i_x  in  N_IN*WIDTH  network input sample
- i_hd_a  in  N_HL_P*WIDTH  hidden activations
- i_dlto  in  N_OUT*WIDTH  output-layer deltas
- i_dlth  in  N_HL_P*WIDTH  hidden-layer deltas
- i_load  in  1  load initial weights; accepted only in IDLE
- i_init_hd_w  in  N_HL_P*N_IN*WIDTH  initial hidden weights
- i_init_hd_b  in  N_HL_P*WIDTH  initial hidden biases
- i_init_out_w  in  N_OUT*N_HL_P*WIDTH  initial output weights
- i_init_out_b  in  N_OUT*WIDTH  initial output biases
- o_hd_w  out  N_HL_P*N_IN*WIDTH  hidden weights; slot h*N_IN+i (h = hidden, i = input, 0-based)
- o_hd_b  out  N_HL_P*WIDTH  hidden biases; slot h
- o_out_w  out  N_OUT*N_HL_P*WIDTH  output weights; slot o*N_HL_P+h, matching the delta stage's i_out_w packing
- o_out_b  out  N_OUT*WIDTH  output biases; slot o
- o_busy  out  1  high outside IDLE
- o_done  out  1  one-cycle pulse when the update completes

## Operation
- States: IDLE, UPD_OUT, UPD_HID, DONE. A single index counter walks the parameters within UPD_OUT and UPD_HID.
- In IDLE:
  - If i_load is high, all init vectors are copied into the weight registers. The state stays IDLE. i_load has priority over i_valid.
  - Otherwise, if i_valid is high, i_x, i_hd_a, i_dlto and i_dlth are captured into internal registers. The state moves to UPD_OUT with the index cleared.
- In UPD_OUT, one parameter is updated per cycle, N_OUT*(N_HL_P+1) cycles in total:
  - Order: for o = 0..N_OUT-1, first w[o][0..N_HL_P-1], then b[o].
  - Weight operand is a = hd_a[h]; bias operand is a = 1.0 (1<<FRAC).
  - Delta is dlto[o].
- In UPD_HID, N_HL_P*(N_IN+1) cycles in total:
  - Order: for h = 0..N_HL_P-1, first w[h][0..N_IN-1], then b[h].
  - Weight operand is x[i]; bias operand is 1.0.
  - Delta is dlth[h].
- Update arithmetic:
  - g = (delta*a) >>> FRAC, using a 2*WIDTH signed product and arithmetic-shift truncation.
  - s = (LR*g) >>> FRAC.
  - w_new = w - s, computed at WIDTH+1 bits, then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- The captured deltas were computed from pre-update weights, so update order has no effect on the results.
- DONE lasts one cycle: o_done=1, then the state returns to IDLE.
- i_valid and i_load are ignored while o_busy=1. No queuing.
- Weight outputs are driven straight from the registers. Each output changes only on the edge where that parameter is updated.

## Timing
- Reset (asynchronous, rst_n=0) puts the block in IDLE and drives all outputs to 0: every weight and bias register, o_busy and o_done. It takes effect immediately, including mid-update. Any partial update is discarded and the weights are zeroed.
- Acceptance edge T: o_busy rises after T.
- With the defaults, 17 updates occur on edges T+1..T+17: output parameters on T+1..T+8, hidden parameters on T+9..T+17.
- DONE follows: o_done=1 in the cycle after edge T+17, o_busy=1 through that cycle.
- The block is back in IDLE after edge T+18. A new i_valid is accepted at edge T+19 at the earliest.
- General latency from acceptance to the o_done cycle is N_OUT*(N_HL_P+1) + N_HL_P*(N_IN+1) + 1 edges.
- An i_load pulse in IDLE updates all outputs on the same edge.

## Test plan
- Reset: assert rst_n=0 mid-UPD_HID -> all outputs 0 immediately, state IDLE, o_busy=0. After release, the next i_valid is accepted normally.
- Single step (Q8.24):
  - Setup: load all weights = 1.0 (0x0100_0000). i_hd_a all = 1.0, i_x all = 1.0, i_dlto = {0.5, 0.5}, i_dlth all = 0.25, LR = 0.5.
  - Response: output weights and biases = 0.75 (0x00C0_0000); hidden weights and biases = 0.875 (0x00E0_0000).
  - o_done pulses exactly 18 cycles after acceptance.
- Sign and ordering: i_dlto = {0, -1.0} with weights 0 and hd_a = {0.5, 1.0, 2.0}:
  - Output 0 weights become {0.25, 0.5, 1.0} and b[0] becomes 0.5; output 1 is unchanged.
  - The o_out_w slot values update one per edge on T+1..T+4.
- Saturation: w = 0x7FFF_FFF0, delta = -127.0, a = 127.0 -> the result clamps to 0x7FFF_FFFF with no wrap. The mirrored case clamps to 0x8000_0000.
- Handshake: pulse i_valid and i_load during busy -> both ignored, weights unaffected. Assert i_load and i_valid together in IDLE -> the load wins and no update sequence starts.

Source files
------------

// File: rtl/weight_update_nn_if.sv
// Port bundle for the weight-update stage: update/load requests in, weight registers and status out.
// Handshake: a request (i_valid or i_load) is taken on a rising edge only while o_busy is low; i_load wins if both are high.
interface weight_update_nn_if #(
  parameter int N_IN   = 2,
  parameter int N_HL_P = 3,
  parameter int N_OUT  = 2,
  parameter int WIDTH  = 32
);
  logic                            i_valid;
  logic [N_IN*WIDTH-1:0]           i_x;
  logic [N_HL_P*WIDTH-1:0]         i_hd_a;
  logic [N_OUT*WIDTH-1:0]          i_dlto;
  logic [N_HL_P*WIDTH-1:0]         i_dlth;
  logic                            i_load;
  logic [N_HL_P*N_IN*WIDTH-1:0]    i_init_hd_w;
  logic [N_HL_P*WIDTH-1:0]         i_init_hd_b;
  logic [N_OUT*N_HL_P*WIDTH-1:0]   i_init_out_w;
  logic [N_OUT*WIDTH-1:0]          i_init_out_b;
  logic [N_HL_P*N_IN*WIDTH-1:0]    o_hd_w;
  logic [N_HL_P*WIDTH-1:0]         o_hd_b;
  logic [N_OUT*N_HL_P*WIDTH-1:0]   o_out_w;
  logic [N_OUT*WIDTH-1:0]          o_out_b;
  logic                            o_busy;
  logic                            o_done;

  modport master (
    output i_valid, i_x, i_hd_a, i_dlto, i_dlth,
    output i_load, i_init_hd_w, i_init_hd_b, i_init_out_w, i_init_out_b,
    input  o_hd_w, o_hd_b, o_out_w, o_out_b, o_busy, o_done
  );

  modport slave (
    input  i_valid, i_x, i_hd_a, i_dlto, i_dlth,
    input  i_load, i_init_hd_w, i_init_hd_b, i_init_out_w, i_init_out_b,
    output o_hd_w, o_hd_b, o_out_w, o_out_b, o_busy, o_done
  );
endinterface

// File: rtl/weight_update_nn.sv
// Sequential gradient-descent step for the 2-3-2 network: one parameter per cycle through a
// single multiply path, output layer first, then hidden layer.
module weight_update_nn #(
  parameter int               N_IN   = 2,
  parameter int               N_HL_P = 3,
  parameter int               N_OUT  = 2,
  parameter int               WIDTH  = 32,
  parameter int               FRAC   = 24,
  parameter logic [WIDTH-1:0] LR     = 32'h0080_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  weight_update_nn_if.slave  bus,
  output logic [1:0]         dbg_state
);

  localparam int N_OUT_P = N_OUT * (N_HL_P + 1);
  localparam int N_HID_P = N_HL_P * (N_IN + 1);
  localparam int N_MAX   = (N_OUT_P > N_HID_P) ? N_OUT_P : N_HID_P;
  localparam int IW      = $clog2(N_MAX);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

  typedef enum logic [1:0] {IDLE, UPD_OUT, UPD_HID, DONE} state_t;

  state_t                          state;
  logic [IW-1:0]                   idx;
  logic                            busy;
  logic                            done;
  logic [N_HL_P*N_IN*WIDTH-1:0]    hd_w_q;
  logic [N_HL_P*WIDTH-1:0]         hd_b_q;
  logic [N_OUT*N_HL_P*WIDTH-1:0]   out_w_q;
  logic [N_OUT*WIDTH-1:0]          out_b_q;
  logic [N_IN*WIDTH-1:0]           x_q;
  logic [N_HL_P*WIDTH-1:0]         hd_a_q;
  logic [N_OUT*WIDTH-1:0]          dlto_q;
  logic [N_HL_P*WIDTH-1:0]         dlth_q;

  int                              unit;
  int                              pos;
  logic                            is_bias;
  logic [WIDTH-1:0]                delta;
  logic [WIDTH-1:0]                a_op;
  logic [WIDTH-1:0]                w_cur;
  logic [2*WIDTH-1:0]              prod_g;
  logic [2*WIDTH-1:0]              prod_s;
  logic [WIDTH-1:0]                g;
  logic [WIDTH-1:0]                s;
  logic [WIDTH:0]                  diff;
  logic [WIDTH-1:0]                w_new;

  // Decode the flat index into (neuron, slot); the slot past the last weight is the bias.
  always_comb begin
    unit    = 0;
    pos     = 0;
    is_bias = 1'b0;
    delta   = '0;
    a_op    = ONE;
    w_cur   = '0;
    if (state == UPD_OUT) begin
      unit    = int'(idx) / (N_HL_P + 1);
      pos     = int'(idx) % (N_HL_P + 1);
      is_bias = (pos == N_HL_P);
      delta   = dlto_q[unit*WIDTH +: WIDTH];
      if (is_bias) begin
        w_cur = out_b_q[unit*WIDTH +: WIDTH];
      end else begin
        a_op  = hd_a_q[pos*WIDTH +: WIDTH];
        w_cur = out_w_q[(unit*N_HL_P + pos)*WIDTH +: WIDTH];
      end
    end else if (state == UPD_HID) begin
      unit    = int'(idx) / (N_IN + 1);
      pos     = int'(idx) % (N_IN + 1);
      is_bias = (pos == N_IN);
      delta   = dlth_q[unit*WIDTH +: WIDTH];
      if (is_bias) begin
        w_cur = hd_b_q[unit*WIDTH +: WIDTH];
      end else begin
        a_op  = x_q[pos*WIDTH +: WIDTH];
        w_cur = hd_w_q[(unit*N_IN + pos)*WIDTH +: WIDTH];
      end
    end
  end

  // Taking bits [FRAC +: WIDTH] of the full product is the arithmetic shift followed by truncation.
  always_comb begin
    prod_g = $signed({{WIDTH{delta[WIDTH-1]}}, delta}) * $signed({{WIDTH{a_op[WIDTH-1]}}, a_op});
    g      = prod_g[FRAC +: WIDTH];
    prod_s = $signed({{WIDTH{LR[WIDTH-1]}}, LR}) * $signed({{WIDTH{g[WIDTH-1]}}, g});
    s      = prod_s[FRAC +: WIDTH];
    diff   = {w_cur[WIDTH-1], w_cur} - {s[WIDTH-1], s};
    if (diff[WIDTH] != diff[WIDTH-1]) begin
      w_new = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      w_new = diff[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hd_w_q  <= '0;
      hd_b_q  <= '0;
      out_w_q <= '0;
      out_b_q <= '0;
      x_q     <= '0;
      hd_a_q  <= '0;
      dlto_q  <= '0;
      dlth_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.i_load) begin
            hd_w_q  <= bus.i_init_hd_w;
            hd_b_q  <= bus.i_init_hd_b;
            out_w_q <= bus.i_init_out_w;
            out_b_q <= bus.i_init_out_b;
          end else if (bus.i_valid) begin
            x_q    <= bus.i_x;
            hd_a_q <= bus.i_hd_a;
            dlto_q <= bus.i_dlto;
            dlth_q <= bus.i_dlth;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= UPD_OUT;
          end
        end
        UPD_OUT: begin
          if (is_bias) out_b_q[unit*WIDTH +: WIDTH] <= w_new;
          else         out_w_q[(unit*N_HL_P + pos)*WIDTH +: WIDTH] <= w_new;
          if (idx == IW'(N_OUT_P - 1)) begin
            idx   <= '0;
            state <= UPD_HID;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        UPD_HID: begin
          if (is_bias) hd_b_q[unit*WIDTH +: WIDTH] <= w_new;
          else         hd_w_q[(unit*N_IN + pos)*WIDTH +: WIDTH] <= w_new;
          if (idx == IW'(N_HID_P - 1)) begin
            idx   <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_hd_w  = hd_w_q;
  assign bus.o_hd_b  = hd_b_q;
  assign bus.o_out_w = out_w_q;
  assign bus.o_out_b = out_b_q;
  assign bus.o_busy  = busy;
  assign bus.o_done  = done;
  assign dbg_state   = state;

endmodule

// File: tb/tb_weight_update_nn.sv
// Scoreboard bench for weight_update_nn: a reference model predicts the final weights of every
// update; a monitor compares them whenever o_done pulses.
module tb_weight_update_nn;

  localparam int          AW   = 544;
  localparam logic [31:0] ONE  = 32'h0100_0000;
  localparam longint      LRV  = 64'h0080_0000;
  localparam longint      MAXV = 64'sd2147483647;
  localparam longint      MINV = -64'sd2147483648;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  weight_update_nn_if bus ();

  weight_update_nn dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q[$];

  logic [31:0] m_hw[6], m_hb[3], m_ow[6], m_ob[2];
  logic [31:0] tx[2], ta[3], tdo[2], tdh[3];
  logic [31:0] ordv[3];
  logic [AW-1:0] dut_all;
  assign dut_all = {bus.o_hd_w, bus.o_hd_b, bus.o_out_w, bus.o_out_b};

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // One gradient step on a single parameter, in plain 64-bit arithmetic.
  function automatic logic [31:0] step(input logic [31:0] w, input logic [31:0] d, input logic [31:0] a);
    longint p;
    longint n;
    logic [31:0] g;
    logic [31:0] s;
    p = longint'($signed(d)) * longint'($signed(a));
    g = p[55:24];
    p = LRV * longint'($signed(g));
    s = p[55:24];
    n = longint'($signed(w)) - longint'($signed(s));
    if (n > MAXV) return 32'h7FFF_FFFF;
    if (n < MINV) return 32'h8000_0000;
    return n[31:0];
  endfunction

  function automatic logic [AW-1:0] pack_m();
    logic [191:0] hw;
    logic [95:0]  hb;
    logic [191:0] ow;
    logic [63:0]  ob;
    for (int k = 0; k < 6; k++) hw[k*32 +: 32] = m_hw[k];
    for (int k = 0; k < 3; k++) hb[k*32 +: 32] = m_hb[k];
    for (int k = 0; k < 6; k++) ow[k*32 +: 32] = m_ow[k];
    for (int k = 0; k < 2; k++) ob[k*32 +: 32] = m_ob[k];
    return {hw, hb, ow, ob};
  endfunction

  function automatic void model_apply();
    for (int o = 0; o < 2; o++) begin
      for (int h = 0; h < 3; h++) m_ow[o*3+h] = step(m_ow[o*3+h], tdo[o], ta[h]);
      m_ob[o] = step(m_ob[o], tdo[o], ONE);
    end
    for (int h = 0; h < 3; h++) begin
      for (int i = 0; i < 2; i++) m_hw[h*2+i] = step(m_hw[h*2+i], tdh[h], tx[i]);
      m_hb[h] = step(m_hb[h], tdh[h], ONE);
    end
  endfunction

  function automatic void model_fill(input logic [31:0] v, input bit rnd);
    for (int k = 0; k < 6; k++) begin
      m_hw[k] = rnd ? $urandom : v;
      m_ow[k] = rnd ? $urandom : v;
    end
    for (int k = 0; k < 3; k++) m_hb[k] = rnd ? $urandom : v;
    for (int k = 0; k < 2; k++) m_ob[k] = rnd ? $urandom : v;
  endfunction

  function automatic void rand_stim();
    for (int k = 0; k < 2; k++) begin tx[k] = $urandom; tdo[k] = $urandom; end
    for (int k = 0; k < 3; k++) begin ta[k] = $urandom; tdh[k] = $urandom; end
  endfunction

  task automatic drive_data();
    for (int k = 0; k < 2; k++) begin bus.i_x[k*32 +: 32] = tx[k]; bus.i_dlto[k*32 +: 32] = tdo[k]; end
    for (int k = 0; k < 3; k++) begin bus.i_hd_a[k*32 +: 32] = ta[k]; bus.i_dlth[k*32 +: 32] = tdh[k]; end
  endtask

  task automatic drive_init();
    for (int k = 0; k < 6; k++) begin
      bus.i_init_hd_w[k*32 +: 32]  = m_hw[k];
      bus.i_init_out_w[k*32 +: 32] = m_ow[k];
    end
    for (int k = 0; k < 3; k++) bus.i_init_hd_b[k*32 +: 32] = m_hb[k];
    for (int k = 0; k < 2; k++) bus.i_init_out_b[k*32 +: 32] = m_ob[k];
  endtask

  task automatic do_load();
    @(negedge clk);
    drive_init();
    bus.i_load = 1'b1;
    @(posedge clk);
    #1 bus.i_load = 1'b0;
    @(negedge clk);
    chk("load_weights", dut_all, pack_m());
    chk32("load_busy", 32'(bus.o_busy), 32'd0);
  endtask

  task automatic start_update();
    @(negedge clk);
    drive_data();
    bus.i_valid = 1'b1;
    model_apply();
    exp_q.push_back(pack_m());
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
  endtask

  // Counts negedges after the acceptance edge; o_done is expected on the 18th.
  task automatic wait_done(input int start_n);
    int  n;
    bit  got;
    n   = start_n;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) chk32("busy_after_accept", 32'(bus.o_busy), 32'd1);
      if (bus.o_done) got = 1'b1;
    end
    chk32("done_latency", 32'(n), 32'd18);
    @(negedge clk);
    chk32("done_pulse_end", {30'd0, bus.o_done, bus.o_busy}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.o_done) begin
      if (exp_q.size() == 0) chk32("unexpected_done", 32'd1, 32'd0);
      else chk("final_weights", dut_all, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [191:0] ow_exp;
    bus.i_valid = 1'b0;  bus.i_load = 1'b0;
    bus.i_x = '0;        bus.i_hd_a = '0;     bus.i_dlto = '0;       bus.i_dlth = '0;
    bus.i_init_hd_w = '0; bus.i_init_hd_b = '0; bus.i_init_out_w = '0; bus.i_init_out_b = '0;
    ordv[0] = 32'h0040_0000; ordv[1] = 32'h0080_0000; ordv[2] = 32'h0100_0000;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_weights", dut_all, '0);
    chk32("reset_status", {28'd0, dbg_state, bus.o_done, bus.o_busy}, 32'd0);
    rst_n = 1'b1;

    // Single step from all-ones weights
    model_fill(ONE, 1'b0);
    do_load();
    for (int k = 0; k < 2; k++) begin tx[k] = ONE; tdo[k] = 32'h0080_0000; end
    for (int k = 0; k < 3; k++) begin ta[k] = ONE; tdh[k] = 32'h0040_0000; end
    start_update();
    wait_done(0);
    chk32("step_out_w0", bus.o_out_w[31:0], 32'h00C0_0000);
    chk32("step_out_b1", bus.o_out_b[63:32], 32'h00C0_0000);
    chk32("step_hd_w5", bus.o_hd_w[191:160], 32'h00E0_0000);
    chk32("step_hd_b2", bus.o_hd_b[95:64], 32'h00E0_0000);

    // Sign and per-edge ordering on the output layer
    model_fill(32'h0, 1'b0);
    do_load();
    rand_stim();
    ta[0] = 32'h0080_0000; ta[1] = ONE; ta[2] = 32'h0200_0000;
    tdo[0] = 32'hFF00_0000; tdo[1] = 32'h0;
    start_update();
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      ow_exp = '0;
      for (int k = 0; k < e; k++) ow_exp[k*32 +: 32] = ordv[k];
      chk("order_out_w", AW'(bus.o_out_w), AW'(ow_exp));
    end
    @(posedge clk);
    #1 chk("order_out_b", AW'(bus.o_out_b), AW'(64'h0000_0000_0080_0000));
    wait_done(4);
    chk("order_out1_unchanged", AW'(bus.o_out_w[191:96]), '0);

    // Saturation in both directions
    model_fill(32'h0, 1'b1);
    m_ow[0] = 32'h7FFF_FFF0;
    m_ow[3] = 32'h8000_0010;
    do_load();
    rand_stim();
    ta[0]  = 32'h7F00_0000;
    tdo[0] = 32'h8100_0000;
    tdo[1] = 32'h7F00_0000;
    start_update();
    wait_done(0);
    chk32("sat_high", bus.o_out_w[31:0], 32'h7FFF_FFFF);
    chk32("sat_low", bus.o_out_w[127:96], 32'h8000_0000);

    // Requests while busy are ignored
    model_fill(32'h0, 1'b1);
    do_load();
    rand_stim();
    start_update();
    repeat (3) @(negedge clk);
    bus.i_x = {2{$urandom}};
    bus.i_dlto = {2{$urandom}};
    bus.i_init_hd_w = {6{$urandom}};
    bus.i_init_out_w = {6{$urandom}};
    bus.i_valid = 1'b1;
    bus.i_load  = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_load  = 1'b0;
    wait_done(4);

    // Load and valid together in IDLE: load wins, no sequence starts
    model_fill(32'h0, 1'b1);
    rand_stim();
    @(negedge clk);
    drive_init();
    drive_data();
    bus.i_load  = 1'b1;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_load  = 1'b0;
    bus.i_valid = 1'b0;
    chk32("load_wins_idle", {29'd0, dbg_state, bus.o_busy}, 32'd0);
    @(negedge clk);
    chk("load_wins_weights", dut_all, pack_m());
    repeat (20) @(negedge clk);
    chk32("load_wins_no_busy", 32'(bus.o_busy), 32'd0);

    // Random loads and back-to-back updates
    for (int it = 0; it < 4; it++) begin
      model_fill(32'h0, 1'b1);
      do_load();
      for (int u = 0; u < 2; u++) begin
        rand_stim();
        if ($urandom_range(0, 1) == 1) tdo[u] = $urandom_range(0, 32'h0200_0000);
        start_update();
        wait_done(0);
      end
    end

    // Asynchronous reset in the middle of the hidden-layer pass
    model_fill(32'h0, 1'b1);
    do_load();
    rand_stim();
    start_update();
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_weights", dut_all, '0);
    chk32("midreset_status", {28'd0, dbg_state, bus.o_done, bus.o_busy}, 32'd0);
    exp_q.delete();
    model_fill(32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    rand_stim();
    start_update();
    wait_done(0);

    repeat (3) @(negedge clk);
    chk32("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
